// File: rtl/serial_comparator_framed.sv
// rtl/serial_comparator_framed.sv - framed serial lt/eq/gt comparator, DIGIT_W bits per beat
// Optional two's-complement operands: define SERIAL_CMP_SIGNED_EN.
module serial_comparator_framed #(
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic               msb_first,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt,
  output logic [CNT_W-1:0]   res_len,
  output logic               res_msb
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_OPEN = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             res_valid_q, res_valid_d;
  logic             res_lt_q, res_lt_d;
  logic             res_gt_q, res_gt_d;
  logic [CNT_W-1:0] res_len_q, res_len_d;
  logic             res_msb_q, res_msb_d;

  logic             accept;
  logic             first;
  logic             mode;
  logic             lt_prev, gt_prev;
  logic             d_lt, d_gt;
  logic             lt_next, gt_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    in_ready = ~res_valid_q | res_ready;
    accept   = in_valid & in_ready;
    first    = (state_q == ST_IDLE);
    mode     = first ? msb_first : mode_q;
    lt_prev  = first ? 1'b0 : lt_q;
    gt_prev  = first ? 1'b0 : gt_q;

`ifdef SERIAL_CMP_SIGNED_EN
    // Sign digit: first beat MSB-first, last beat LSB-first; a single-beat frame is both.
    if ((mode && first) || (!mode && in_last)) begin
      d_lt = $signed(a) < $signed(b);
      d_gt = $signed(a) > $signed(b);
    end else begin
      d_lt = a < b;
      d_gt = a > b;
    end
`else
    d_lt = a < b;
    d_gt = a > b;
`endif

    if (mode) begin
      // MSB-first: first non-equal digit is final
      lt_next = (lt_prev | gt_prev) ? lt_prev : d_lt;
      gt_next = (lt_prev | gt_prev) ? gt_prev : d_gt;
    end else begin
      lt_next = (d_lt | d_gt) ? d_lt : lt_prev;
      gt_next = (d_lt | d_gt) ? d_gt : gt_prev;
    end

    if (first)                cnt_next = CNT_ONE;
    else if (cnt_q == CNT_MAX) cnt_next = CNT_MAX;
    else                      cnt_next = cnt_q + CNT_ONE;

    state_d     = state_q;
    mode_d      = mode_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q & ~res_ready;
    res_lt_d    = res_lt_q;
    res_gt_d    = res_gt_q;
    res_len_d   = res_len_q;
    res_msb_d   = res_msb_q;

    if (accept) begin
      if (in_last) begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b1;
        res_lt_d    = lt_next;
        res_gt_d    = gt_next;
        res_len_d   = cnt_next;
        res_msb_d   = mode;
      end else begin
        state_d = ST_OPEN;
        mode_d  = mode;
        lt_d    = lt_next;
        gt_d    = gt_next;
        cnt_d   = cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_lt_q    <= 1'b0;
      res_gt_q    <= 1'b0;
      res_len_q   <= '0;
      res_msb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_lt_q    <= res_lt_d;
      res_gt_q    <= res_gt_d;
      res_len_q   <= res_len_d;
      res_msb_q   <= res_msb_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_lt    = res_lt_q;
  assign res_gt    = res_gt_q;
  assign res_eq    = res_valid_q & ~res_lt_q & ~res_gt_q;
  assign res_len   = res_len_q;
  assign res_msb   = res_msb_q;

endmodule

// File: tb/tb_serial_comparator_framed.sv
// tb/tb_serial_comparator_framed.sv - scoreboard bench for serial_comparator_framed (DIGIT_W=1 and 4)
module tb_serial_comparator_framed;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  typedef struct packed {
    logic       lt;
    logic       eq;
    logic       gt;
    logic [7:0] len;
    logic       msb;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid [2];
  logic       in_ready [2];
  logic       in_last  [2];
  logic       msb_first[2];
  logic [3:0] a_s      [2];
  logic [3:0] b_s      [2];
  logic       res_valid[2];
  logic       res_ready[2];
  logic       res_lt   [2];
  logic       res_eq   [2];
  logic       res_gt   [2];
  logic [7:0] res_len  [2];
  logic       res_msb  [2];

  res_t q0[$];
  res_t q1[$];
  int   n_err;
  int   n_chk;
  bit   bp_en;

  serial_comparator_framed #(.DIGIT_W(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_last(in_last[0]),
    .msb_first(msb_first[0]), .a(a_s[0][0:0]), .b(b_s[0][0:0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_lt(res_lt[0]), .res_eq(res_eq[0]), .res_gt(res_gt[0]),
    .res_len(res_len[0]), .res_msb(res_msb[0])
  );

  serial_comparator_framed #(.DIGIT_W(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_last(in_last[1]),
    .msb_first(msb_first[1]), .a(a_s[1]), .b(b_s[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_lt(res_lt[1]), .res_eq(res_eq[1]), .res_gt(res_gt[1]),
    .res_len(res_len[1]), .res_msb(res_msb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan digits from most significant; top digit is signed when enabled.
  function automatic res_t model(input int k, input logic [511:0] av, input logic [511:0] bv,
                                 input int n, input logic msb);
    res_t r;
    int   dw;
    int   da, db;
    dw    = (k == 0) ? 1 : 4;
    r.lt  = 1'b0;
    r.gt  = 1'b0;
    r.len = (n > 255) ? 8'd255 : 8'(n);
    r.msb = msb;
    for (int i = n - 1; i >= 0; i--) begin
      da = 0;
      db = 0;
      for (int j = 0; j < dw; j++) begin
        da = da | (int'(av[i*dw+j]) << j);
        db = db | (int'(bv[i*dw+j]) << j);
      end
      if (da != db) begin
        if (SIGNED && i == n - 1) begin
          if (((da >> (dw - 1)) & 1) == 1) da = da - (1 << dw);
          if (((db >> (dw - 1)) & 1) == 1) db = db - (1 << dw);
        end
        r.lt = (da < db);
        r.gt = (da > db);
        break;
      end
    end
    r.eq = ~r.lt & ~r.gt;
    return r;
  endfunction

  task automatic push(input int k, input res_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that took the last beat.
  task automatic send(input int k, input logic [511:0] av, input logic [511:0] bv,
                      input int n, input logic msb);
    int  dw;
    int  idx;
    int  tmo;
    bit  took;
    dw = (k == 0) ? 1 : 4;
    push(k, model(k, av, bv, n, msb));
    for (int j = 0; j < n; j++) begin
      idx = msb ? (n - 1 - j) : j;
      a_s[k] = '0;
      b_s[k] = '0;
      for (int t = 0; t < dw; t++) begin
        a_s[k][t] = av[idx*dw+t];
        b_s[k][t] = bv[idx*dw+t];
      end
      in_valid[k]  = 1'b1;
      in_last[k]   = (j == n - 1);
      msb_first[k] = msb;
      tmo  = 0;
      took = 1'b0;
      while (!took) begin
        if (bp_en) res_ready[k] = 1'($urandom_range(0, 1));
        @(negedge clk);
        took = in_ready[k];
        @(posedge clk);
        #1;
        tmo++;
        if (!took && tmo > 200) begin
          check("beat_timeout", 1, 0);
          in_valid[k] = 1'b0;
          return;
        end
      end
    end
    in_valid[k] = 1'b0;
    check("latency_valid", res_valid[k], 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid[0] && res_ready[0]) begin
      if (q0.size() == 0) check("unexpected_res_w1", 1, 0);
      else check("res_w1", {res_lt[0], res_eq[0], res_gt[0], res_len[0], res_msb[0]}, q0.pop_front());
    end
    if (rst_n && res_valid[1] && res_ready[1]) begin
      if (q1.size() == 0) check("unexpected_res_w4", 1, 0);
      else check("res_w4", {res_lt[1], res_eq[1], res_gt[1], res_len[1], res_msb[1]}, q1.pop_front());
    end
  end

  task automatic tick(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e;
    n_err = 0;
    n_chk = 0;
    bp_en = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_last[k] = 1'b0; msb_first[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0; res_ready[k] = 1'b1;
    end
    tick(3);
    check("rst_res", {res_valid[0], res_lt[0], res_eq[0], res_gt[0], res_len[0], res_msb[0]}, 0);
    check("rst_res4", {res_valid[1], res_lt[1], res_eq[1], res_gt[1], res_len[1], res_msb[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {in_ready[0], in_ready[1]}, 2'b11);

    // 1-bit MSB-first gt, then LSB-first / MSB-first pair
    send(0, 512'b1011, 512'b1001, 4, 1'b1);
    send(0, 512'b0110, 512'b0101, 4, 1'b0);
    send(0, 512'b0110, 512'b0101, 4, 1'b1);
    // 4-bit single-beat equal then back-to-back lt
    send(1, 512'h7, 512'h7, 1, 1'b1);
    send(1, 512'h2, 512'h9, 1, 1'b1);
    // sign handling (gt unsigned, lt signed)
    send(1, 512'hF0, 512'h10, 2, 1'b1);
    send(1, 512'hF0, 512'h10, 2, 1'b0);
    send(1, 512'h8, 512'h1, 1, 1'b0);
    tick(3);

    // Stalled result: in_ready low for 5 cycles, then drain and accept together
    res_ready[1] = 1'b0;
    send(1, 512'h35, 512'h34, 2, 1'b1);
    e = model(1, 512'h35, 512'h34, 2, 1'b1);
    push(1, model(1, 512'h4, 512'hC, 1, 1'b0));
    in_valid[1] = 1'b1; in_last[1] = 1'b1; msb_first[1] = 1'b0;
    a_s[1] = 4'h4; b_s[1] = 4'hC;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready[1], 0);
      check("stall_hold", {res_valid[1], res_lt[1], res_eq[1], res_gt[1], res_len[1]}, {1'b1, e.lt, e.eq, e.gt, e.len});
      @(posedge clk); #1;
    end
    res_ready[1] = 1'b1;
    @(negedge clk);
    check("drain_in_ready", in_ready[1], 1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    check("reload_valid", res_valid[1], 1);
    tick(3);

    // Reset in mid-frame discards the partial frame
    in_valid[0] = 1'b1; in_last[0] = 1'b0; msb_first[0] = 1'b1;
    a_s[0] = 4'h1; b_s[0] = 4'h0;
    tick(2);
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_valid", {res_valid[0], res_valid[1]}, 0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 512'b0001, 512'b0010, 4, 1'b1);

    // Comparison past beat-count saturation
    send(0, 512'd0, 512'd1, 300, 1'b1);
    send(0, 512'd1 << 299, 512'd1, 300, 1'b0);
    tick(3);

    // Random frames under random back-pressure
    bp_en = 1'b1;
    for (int r = 0; r < 24; r++) begin
      logic [511:0] av, bv;
      int k;
      k  = r % 2;
      av = {480'd0, 32'($urandom)};
      bv = (($urandom_range(0, 3)) == 0) ? av : {480'd0, 32'($urandom)};
      send(k, av, bv, int'($urandom_range(1, (k == 0) ? 20 : 8)), 1'($urandom_range(0, 1)));
    end
    bp_en = 1'b0;
    res_ready[0] = 1'b1;
    res_ready[1] = 1'b1;
    tick(10);
    check("sb_empty", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
